// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer slice.
//   - Default array geometry and widths, and the derived constants
//     (log2 of the array sides, drain length, beat counter type) for that
//     default configuration.
//   - Sequencer state encoding shared by RTL and bench.
//   - drain_cycles(): the array fill/drain latency for any geometry.
package mm_pkg;

  localparam int N1_DEF           = 4;
  localparam int N2_DEF           = 4;
  localparam int MATRIXSIZE_W_DEF = 16;
  localparam int PIPE_LAT_DEF     = 8;

  localparam int LOG2_N1 = $clog2(N1_DEF);
  localparam int LOG2_N2 = $clog2(N2_DEF);

  // A result leaves the array N1+N2-2 cycles after its last operand enters,
  // plus whatever the PE multiply/accumulate pipeline adds.
  function automatic int drain_cycles(input int n1, input int n2, input int pipe_lat);
    return n1 + n2 + pipe_lat - 2;
  endfunction

  localparam int DRAIN_CYC = drain_cycles(N1_DEF, N2_DEF, PIPE_LAT_DEF);

  // M1*M2 beats never truncate when held at twice the dimension width.
  typedef logic [2*MATRIXSIZE_W_DEF-1:0] beat_cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_STREAM,
    S_LASTCHK,
    S_DRAIN,
    S_FLUSH,
    S_WAITWB,
    S_DONE
  } mm_state_t;

endpackage

// File: rtl/mm_seq_ctrl_if.sv
// Bundle of every job, generator and write-back signal seen by the
// sequencer.
//   master : host/config layer, A/B generators and write-back side
//            (drives start, M1..M3, last_addr_A/B, stall, wb_done)
//   slave  : the sequencer itself (drives busy, done, cfg_err, seq_err,
//            M2_q, M1dN1, M3dN2, gen_rst, rd_en_A/B, flush)
interface mm_seq_ctrl_if #(
  parameter int MATRIXSIZE_W = 16
) ();

  logic                    start;
  logic [MATRIXSIZE_W-1:0] M1;
  logic [MATRIXSIZE_W-1:0] M2;
  logic [MATRIXSIZE_W-1:0] M3;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;
  logic                    seq_err;
  logic [MATRIXSIZE_W-1:0] M2_q;
  logic [MATRIXSIZE_W-1:0] M1dN1;
  logic [MATRIXSIZE_W-1:0] M3dN2;
  logic                    gen_rst;
  logic                    rd_en_A;
  logic                    rd_en_B;
  logic                    last_addr_A;
  logic                    last_addr_B;
  logic                    stall;
  logic                    flush;
  logic                    wb_done;

  modport master (
    output start, M1, M2, M3, last_addr_A, last_addr_B, stall, wb_done,
    input  busy, done, cfg_err, seq_err, M2_q, M1dN1, M3dN2,
           gen_rst, rd_en_A, rd_en_B, flush
  );

  modport slave (
    input  start, M1, M2, M3, last_addr_A, last_addr_B, stall, wb_done,
    output busy, done, cfg_err, seq_err, M2_q, M1dN1, M3dN2,
           gen_rst, rd_en_A, rd_en_B, flush
  );

endinterface

// File: rtl/mm_cfg_check.sv
// Combinational job validation for the sequencer's CHECK state.
//   m1, m2, m3  : latched job dimensions
//   cfg_ok      : all dimensions non-zero, M1 a multiple of N1, M3 a
//                 multiple of N2
//   m1_div_n1   : M1 / N1 (exact when cfg_ok)
//   m3_div_n2   : M3 / N2 (exact when cfg_ok)
// N1 and N2 are powers of two, so divisibility is a zero test on the low
// bits and division is a right shift.
module mm_cfg_check
  import mm_pkg::*;
#(
  parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEF,
  parameter int SH1          = LOG2_N1,
  parameter int SH2          = LOG2_N2
) (
  input  logic [MATRIXSIZE_W-1:0] m1,
  input  logic [MATRIXSIZE_W-1:0] m2,
  input  logic [MATRIXSIZE_W-1:0] m3,
  output logic                    cfg_ok,
  output logic [MATRIXSIZE_W-1:0] m1_div_n1,
  output logic [MATRIXSIZE_W-1:0] m3_div_n2
);

  logic dims_nonzero;
  logic m1_aligned;
  logic m3_aligned;

  assign dims_nonzero = (m1 != '0) && (m2 != '0) && (m3 != '0);
  assign m1_aligned   = (m1[SH1-1:0] == '0);
  assign m3_aligned   = (m3[SH2-1:0] == '0);

  assign cfg_ok    = dims_nonzero && m1_aligned && m3_aligned;
  assign m1_div_n1 = m1 >> SH1;
  assign m3_div_n2 = m3 >> SH2;

endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencer for one C = A x B job on the N1 x N2 systolic array.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mm_seq_ctrl_if
//     start/M1/M2/M3 in  : job request, sampled only in IDLE
//     busy               : accepted start through the done cycle
//     done / cfg_err     : one-cycle completion / rejection pulses
//     seq_err            : sticky last-flag mismatch, cleared by next start
//     M2_q/M1dN1/M3dN2   : latched geometry for the address generators
//     gen_rst            : one-cycle generator reset on job acceptance
//     rd_en_A/rd_en_B    : generator step enables while streaming
//     last_addr_A/B in   : registered last flags from the generators
//     stall in           : freezes streaming (ignored while draining)
//     flush / wb_done    : write-back kick-off pulse and its completion
// Flow: IDLE -> CHECK -> STREAM -> LASTCHK -> DRAIN -> FLUSH -> WAITWB
// -> DONE -> IDLE; a rejected job returns from CHECK straight to IDLE.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int N1           = N1_DEF,
  parameter int N2           = N2_DEF,
  parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEF,
  parameter int PIPE_LAT     = PIPE_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mm_seq_ctrl_if.slave  bus
);

  localparam int LG_N1   = $clog2(N1);
  localparam int LG_N2   = $clog2(N2);
  localparam int DRAIN_D = drain_cycles(N1, N2, PIPE_LAT);
  localparam int DW      = $clog2(DRAIN_D);

  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_D - 1);

  typedef logic [MATRIXSIZE_W-1:0]   dim_t;
  typedef logic [2*MATRIXSIZE_W-1:0] tot_t;

  mm_state_t     state_q,     state_d;
  dim_t          m1_q,        m1_d;
  dim_t          m2_q,        m2_d;
  dim_t          m3_q,        m3_d;
  dim_t          m1dn1_q,     m1dn1_d;
  dim_t          m3dn2_q,     m3dn2_d;
  tot_t          tot_q,       tot_d;
  tot_t          beat_cnt_q,  beat_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          seq_err_q,   seq_err_d;

  logic cfg_ok;
  dim_t chk_m1dn1;
  dim_t chk_m3dn2;
  logic beat_en;

  mm_cfg_check #(
    .MATRIXSIZE_W (MATRIXSIZE_W),
    .SH1          (LG_N1),
    .SH2          (LG_N2)
  ) u_cfg_check (
    .m1        (m1_q),
    .m2        (m2_q),
    .m3        (m3_q),
    .cfg_ok    (cfg_ok),
    .m1_div_n1 (chk_m1dn1),
    .m3_div_n2 (chk_m3dn2)
  );

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      m1_q        <= '0;
      m2_q        <= '0;
      m3_q        <= '0;
      m1dn1_q     <= '0;
      m3dn2_q     <= '0;
      tot_q       <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      m3_q        <= m3_d;
      m1dn1_q     <= m1dn1_d;
      m3dn2_q     <= m3dn2_d;
      tot_q       <= tot_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    m3_d        = m3_q;
    m1dn1_d     = m1dn1_q;
    m3dn2_d     = m3dn2_q;
    tot_d       = tot_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = '0;
    seq_err_d   = seq_err_q;
    beat_en     = 1'b0;
    bus.cfg_err = 1'b0;
    bus.gen_rst = 1'b0;
    bus.flush   = 1'b0;
    bus.done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m1_d      = bus.M1;
          m2_d      = bus.M2;
          m3_d      = bus.M3;
          seq_err_d = 1'b0;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        if (!cfg_ok) begin
          bus.cfg_err = 1'b1;
          state_d     = S_IDLE;
        end else begin
          bus.gen_rst = 1'b1;
          m1dn1_d     = chk_m1dn1;
          m3dn2_d     = chk_m3dn2;
          tot_d       = tot_t'(m1_q) * tot_t'(m2_q);
          beat_cnt_d  = '0;
          state_d     = S_STREAM;
        end
      end

      S_STREAM: begin
        beat_en = !bus.stall;
        // Any last flag while beats remain means a generator ran short.
        if (bus.last_addr_A || bus.last_addr_B) seq_err_d = 1'b1;
        if (beat_en) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_d == tot_q) state_d = S_LASTCHK;
        end
      end

      S_LASTCHK: begin
        // The generators register last one cycle after the final beat.
        if (!(bus.last_addr_A && bus.last_addr_B)) seq_err_d = 1'b1;
        state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_FLUSH;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      S_FLUSH: begin
        bus.flush = 1'b1;
        state_d   = S_WAITWB;
      end

      S_WAITWB: begin
        if (bus.wb_done) state_d = S_DONE;
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    bus.rd_en_A = beat_en;
    bus.rd_en_B = beat_en;
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.seq_err = seq_err_q;
  assign bus.M2_q    = m2_q;
  assign bus.M1dN1   = m1dn1_q;
  assign bus.M3dN2   = m3dn2_q;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl (N1=N2=4, PIPE_LAT=8, 16-bit dims).
// Cycle 0 of a job is the cycle in which start is presented; CHECK is
// cycle 1. The bench plays the A/B generators (counting rd_en beats and
// raising both last flags the cycle after the final beat) and write-back
// (wb_done wb_lat cycles after flush), and logs every output per cycle.
module tb_mm_seq_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mm_seq_ctrl_if #(.MATRIXSIZE_W(16)) bus ();

  mm_seq_ctrl #(
    .N1           (4),
    .N2           (4),
    .MATRIXSIZE_W (16),
    .PIPE_LAT     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Job configuration consumed by run_job.
  logic [15:0] j_m1, j_m2, j_m3;
  logic [15:0] j2_m1, j2_m2, j2_m3;
  int s1_from, s1_len, s2_from, s2_len;
  int early_a_cyc, rst_cyc, start2_from, start2_len;
  int wb_lat, post, max_cyc;
  bit give_a, give_b;

  // Per-cycle output logs, bit index = cycle number within the job.
  logic [255:0] busy_v, done_v, cfg_err_v, seq_err_v, gen_rst_v;
  logic [255:0] rd_a_v, rd_b_v, flush_v, stall_v, zero_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_one(input logic [255:0] v);
    for (int i = 0; i < 256; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int last_one(input logic [255:0] v);
    for (int i = 255; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit in_win(input int c, input int from, input int len);
    return (c >= from) && (c < from + len);
  endfunction

  task automatic set_defaults();
    j_m1 = 16'd8; j_m2 = 16'd3; j_m3 = 16'd4;
    j2_m1 = 16'd8; j2_m2 = 16'd3; j2_m3 = 16'd4;
    s1_from = 0; s1_len = 0; s2_from = 0; s2_len = 0;
    early_a_cyc = -1; rst_cyc = -1; start2_from = -1; start2_len = 0;
    wb_lat = 3; post = 2; max_cyc = 120;
    give_a = 1'b1; give_b = 1'b1;
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.stall = 1'b0; bus.wb_done = 1'b0;
    bus.last_addr_A = 1'b0; bus.last_addr_B = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic log_cycle(input int c);
    busy_v[c]    = bus.busy;
    done_v[c]    = bus.done;
    cfg_err_v[c] = bus.cfg_err;
    seq_err_v[c] = bus.seq_err;
    gen_rst_v[c] = bus.gen_rst;
    rd_a_v[c]    = bus.rd_en_A;
    rd_b_v[c]    = bus.rd_en_B;
    flush_v[c]   = bus.flush;
    stall_v[c]   = bus.stall;
    zero_v[c]    = ~|{bus.busy, bus.done, bus.cfg_err, bus.seq_err, bus.gen_rst,
                      bus.rd_en_A, bus.rd_en_B, bus.flush,
                      bus.M2_q, bus.M1dN1, bus.M3dN2};
  endtask

  task automatic run_job();
    longint tgt, beats;
    bit last_pend, stop;
    int c, flush_cyc, done_cyc;
    tgt = longint'(j_m1) * longint'(j_m2);
    beats = 0; last_pend = 1'b0; flush_cyc = -1000; done_cyc = -1;
    busy_v = '0; done_v = '0; cfg_err_v = '0; seq_err_v = '0; gen_rst_v = '0;
    rd_a_v = '0; rd_b_v = '0; flush_v = '0; stall_v = '0; zero_v = '0;
    @(posedge clk); #1;
    drive_idle();
    bus.start = 1'b1; bus.M1 = j_m1; bus.M2 = j_m2; bus.M3 = j_m3;
    #1; log_cycle(0);
    c = 0; stop = 1'b0;
    while (!stop) begin
      @(posedge clk); #1;
      c++;
      if (in_win(c, start2_from, start2_len)) begin
        bus.start = 1'b1; bus.M1 = j2_m1; bus.M2 = j2_m2; bus.M3 = j2_m3;
      end else begin
        bus.start = 1'b0;
      end
      rst             = (c == rst_cyc);
      bus.stall       = in_win(c, s1_from, s1_len) || in_win(c, s2_from, s2_len);
      bus.last_addr_A = (last_pend && give_a) || (c == early_a_cyc);
      bus.last_addr_B = last_pend && give_b;
      bus.wb_done     = (c == flush_cyc + wb_lat);
      #1; log_cycle(c);
      if (bus.gen_rst) beats = 0;
      last_pend = 1'b0;
      if (bus.rd_en_A) begin
        beats++;
        last_pend = (beats == tgt);
      end
      if (bus.flush) flush_cyc = c;
      if (bus.done && done_cyc < 0) done_cyc = c;
      if ((done_cyc >= 0 && c >= done_cyc + post) || c >= max_cyc - 1 || c >= 255)
        stop = 1'b1;
    end
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [15:0] rj_m1 [3];
  logic [15:0] rj_m2 [3];
  logic [15:0] rj_m3 [3];

  initial begin
    bus.M1 = '0; bus.M2 = '0; bus.M3 = '0;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;

    // Reset state.
    check("rst_busy",    bus.busy, 0);
    check("rst_done",    bus.done, 0);
    check("rst_seq_err", bus.seq_err, 0);
    check("rst_all_out", {bus.cfg_err, bus.gen_rst, bus.rd_en_A, bus.rd_en_B, bus.flush,
                          bus.M2_q, bus.M1dN1, bus.M3dN2}, 0);

    // Basic job 8x3x4: 24 beats in cycles 2..25, LASTCHK 26, DRAIN 27..40,
    // flush 41, wb_done 44, done 45.
    set_defaults();
    run_job();
    check("basic_busy_c0",     busy_v[0], 0);
    check("basic_busy_c1",     busy_v[1], 1);
    check("basic_gen_rst_cyc", 64'(first_one(gen_rst_v)), 1);
    check("basic_gen_rst_cnt", $countones(gen_rst_v), 1);
    check("basic_rd_first",    64'(first_one(rd_a_v)), 2);
    check("basic_rd_last",     64'(last_one(rd_a_v)), 25);
    check("basic_rd_cnt",      $countones(rd_a_v), 24);
    check("basic_rd_b_eq_a",   rd_b_v == rd_a_v, 1);
    check("basic_flush_cyc",   64'(first_one(flush_v)), 41);
    check("basic_flush_cnt",   $countones(flush_v), 1);
    check("basic_done_cyc",    64'(first_one(done_v)), 45);
    check("basic_done_cnt",    $countones(done_v), 1);
    check("basic_busy_done",   busy_v[45], 1);
    check("basic_busy_after",  busy_v[46], 0);
    check("basic_seq_err",     $countones(seq_err_v), 0);
    check("basic_cfg_err",     $countones(cfg_err_v), 0);
    check("basic_m1dn1",       bus.M1dN1, 2);
    check("basic_m3dn2",       bus.M3dN2, 1);
    check("basic_m2_q",        bus.M2_q, 3);

    // Rejected jobs: cfg_err in CHECK (cycle 1), idle again in cycle 2.
    rj_m1 = '{16'd6, 16'd8, 16'd8};
    rj_m2 = '{16'd3, 16'd3, 16'd0};
    rj_m3 = '{16'd4, 16'd0, 16'd4};
    for (int i = 0; i < 3; i++) begin
      set_defaults();
      j_m1 = rj_m1[i]; j_m2 = rj_m2[i]; j_m3 = rj_m3[i];
      max_cyc = 8;
      run_job();
      check($sformatf("rej%0d_cfg_err_cyc", i), 64'(first_one(cfg_err_v)), 1);
      check($sformatf("rej%0d_cfg_err_cnt", i), $countones(cfg_err_v), 1);
      check($sformatf("rej%0d_busy_c1", i),     busy_v[1], 1);
      check($sformatf("rej%0d_busy_c2", i),     busy_v[2], 0);
      check($sformatf("rej%0d_gen_rst", i),     $countones(gen_rst_v), 0);
      check($sformatf("rej%0d_rd_en", i),       $countones(rd_a_v | rd_b_v), 0);
      check($sformatf("rej%0d_done", i),        $countones(done_v), 0);
    end

    // Stall 5 cycles mid-stream (6..10) and 2 cycles on the final beat
    // (30..31): beat 24 at 32, flush 48, done 52 (seven cycles later).
    set_defaults();
    s1_from = 6; s1_len = 5; s2_from = 30; s2_len = 2;
    run_job();
    check("stall_rd_cnt",     $countones(rd_a_v), 24);
    check("stall_rd_blocked", $countones((rd_a_v | rd_b_v) & stall_v), 0);
    check("stall_rd_b_eq_a",  rd_b_v == rd_a_v, 1);
    check("stall_rd_last",    64'(last_one(rd_a_v)), 32);
    check("stall_flush_cyc",  64'(first_one(flush_v)), 48);
    check("stall_done_cyc",   64'(first_one(done_v)), 52);

    // last_addr_B withheld in LASTCHK (cycle 26): seq_err from 27, job completes.
    set_defaults();
    give_b = 1'b0;
    run_job();
    check("lastb_seq_err_c26", seq_err_v[26], 0);
    check("lastb_seq_err_c27", seq_err_v[27], 1);
    check("lastb_done_cyc",    64'(first_one(done_v)), 45);
    check("lastb_seq_err_done", seq_err_v[45], 1);
    check("lastb_sticky_idle", bus.seq_err, 1);

    // Early last_addr_A on beat 10 (cycle 11); accepted start clears the old flag.
    set_defaults();
    early_a_cyc = 11;
    run_job();
    check("early_seq_err_c0",   seq_err_v[0], 1);
    check("early_seq_err_c1",   seq_err_v[1], 0);
    check("early_seq_err_c11",  seq_err_v[11], 0);
    check("early_seq_err_c12",  seq_err_v[12], 1);
    check("early_done_cyc",     64'(first_one(done_v)), 45);
    check("early_seq_err_done", seq_err_v[45], 1);

    // Reset in DRAIN (cycle 30): all outputs zero in cycle 31, no done.
    set_defaults();
    rst_cyc = 30; max_cyc = 60;
    run_job();
    check("drst_busy_c30",  busy_v[30], 1);
    check("drst_zero_c31",  zero_v[31], 1);
    check("drst_done",      $countones(done_v), 0);
    check("drst_flush",     $countones(flush_v), 0);
    check("drst_cfg_err",   $countones(cfg_err_v), 0);

    // start during STREAM (cycle 10) with other dims is ignored.
    set_defaults();
    start2_from = 10; start2_len = 1;
    j2_m1 = 16'd4; j2_m2 = 16'd1; j2_m3 = 16'd4;
    post = 3;
    run_job();
    check("ign_gen_rst_cnt", $countones(gen_rst_v), 1);
    check("ign_rd_cnt",      $countones(rd_a_v), 24);
    check("ign_done_cnt",    $countones(done_v), 1);
    check("ign_done_cyc",    64'(first_one(done_v)), 45);
    check("ign_m2_q",        bus.M2_q, 3);

    // Back-to-back: start held in DONE (45) and the following IDLE cycle
    // (46); only the IDLE one is taken, so the second CHECK is cycle 47.
    set_defaults();
    start2_from = 45; start2_len = 2;
    j2_m1 = 16'd8; j2_m2 = 16'd2; j2_m3 = 16'd4;
    post = 3;
    run_job();
    check("b2b_done_cyc",     64'(first_one(done_v)), 45);
    check("b2b_busy_c46",     busy_v[46], 0);
    check("b2b_busy_c47",     busy_v[47], 1);
    check("b2b_gen_rst_cnt",  $countones(gen_rst_v), 2);
    check("b2b_gen_rst_2nd",  64'(last_one(gen_rst_v)), 47);
    check("b2b_m2_q",         bus.M2_q, 2);
    do_reset();

    // Maximum dimensions: beat target 0xFFFC*0xFFFC without truncation.
    set_defaults();
    j_m1 = 16'hFFFC; j_m2 = 16'hFFFC; j_m3 = 16'hFFFC;
    max_cyc = 6;
    run_job();
    check("max_cfg_err",  $countones(cfg_err_v), 0);
    check("max_gen_rst",  64'(first_one(gen_rst_v)), 1);
    check("max_rd_cnt",   $countones(rd_a_v), 4);
    check("max_tot",      64'(dut.tot_q), 64'hFFF8_0010);
    check("max_m1dn1",    bus.M1dN1, 16'h3FFF);
    check("max_m3dn2",    bus.M3dN2, 16'h3FFF);
    check("max_m2_q",     bus.M2_q, 16'hFFFC);
    do_reset();
    #1;
    check("max_abort_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
